// File: rtl/toggle_cover_collector_pkg.sv
// cover_pkg: shared types, defaults and helpers for the cover collectors
package cover_pkg;
  localparam int COVER_TOTAL_DEFAULT = 9715;
  localparam int IDX_W_DEFAULT = 64;
  typedef logic [IDX_W_DEFAULT-1:0] cover_idx_t;
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/toggle_cover_collector_if.sv
// toggle_cover_collector_if: ready/valid stream of newly covered global indices
interface toggle_cover_collector_if #(parameter int IDX_W = 64);
  logic report_valid;
  logic report_ready;
  logic [IDX_W-1:0] report_index;
  modport master (output report_valid, output report_index, input report_ready);
  modport slave (input report_valid, input report_index, output report_ready);
endinterface

// File: rtl/toggle_cover_collector_lowest_set_enc.sv
// lowest_set_enc: priority encoder returning the lowest set bit position
module lowest_set_enc
  import cover_pkg::*;
#(
  parameter int WIDTH = 28,
  localparam int IW = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] v,
  output logic             any,
  output logic [IW-1:0]    idx
);
  always_comb begin
    any = |v;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) idx = IW'(i);
  end
endmodule

// File: rtl/toggle_cover_collector.sv
// toggle_cover_collector: sticky cover bitmap reporting each point once on first hit
module toggle_cover_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = COVER_TOTAL_DEFAULT,
  parameter int IDX_W       = IDX_W_DEFAULT,
  parameter int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        valid,
  input  logic                    clear,
  toggle_cover_collector_if.master rpt,
  output logic [CNT_W-1:0]        covered_count,
  output logic                    all_covered
);
  localparam int IW = clog2_safe(WIDTH);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end
  if (IDX_W < clog2_safe(COVER_TOTAL)) begin : g_bad_idx_w
    $error("IDX_W too narrow for COVER_TOTAL");
  end

  logic [WIDTH-1:0] covered, pending, new_hit, cand, pend_n;
  logic             rv, free, any;
  logic [IDX_W-1:0] ridx;
  logic [IW-1:0]    sel;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) popcount += CNT_W'(v[i]);
  endfunction

  // fresh hits join the candidate set so a lone hit reports next cycle
  assign new_hit = valid & ~covered;
  assign cand    = pending | new_hit;
  assign free    = !rv || rpt.report_ready;

  lowest_set_enc #(.WIDTH(WIDTH)) u_enc (.v(cand), .any(any), .idx(sel));

  always_comb begin
    pend_n = cand;
    if (free && any) pend_n[sel] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      rv            <= 1'b0;
      ridx          <= '0;
    end else begin
      covered       <= covered | new_hit;
      pending       <= pend_n;
      covered_count <= covered_count + popcount(new_hit);
      if (free) begin
        rv <= any;
        if (any) ridx <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
      end
    end
  end

  assign rpt.report_valid = rv;
  assign rpt.report_index = ridx;
  assign all_covered      = covered_count == CNT_W'(WIDTH);
endmodule
